// File: rtl/spi_latency_reader.sv
// -----------------------------------------------------------------------------
// spi_latency_reader
//
// Purpose: services a latency target over an interrupt / interrupt_ack
// handshake and then reads two 32-bit latency counts from it with one
// 8-byte SPI frame (mode 3, MSB first within a byte, little-endian bytes).
// After reset, a single throw-away 1-byte SPI transfer is performed first.
//
// Handshake: the target raises interrupt. After ACK_DELAY cycles we raise
// interrupt_ack. The target drops interrupt. GAP cycles later the SPI
// frame runs. interrupt_ack stays high until the frame has been
// consumed (DONE), or until TIMEOUT expires while interrupt is still high.
// A new interrupt is not accepted until 2 cycles after interrupt_ack falls.
//
// Ports:
//   clk, rst         system clock; asynchronous active-high reset
//   interrupt        request from target (2-flop synchronized)
//   interrupt_ack    acknowledge to target
//   SCK/SSEL/MOSI    SPI master outputs (SCK idles high, SSEL active low)
//   MISO             SPI data in (2-flop synchronized)
//   int_ack_latency  bytes 0..3 of the last complete frame
//   spi_latency      bytes 4..7 of the last complete frame
//   result_valid     one-cycle pulse when both results load
//   timeout_err      sticky ack-timeout flag
//   busy             high whenever the FSM is not in WAIT_INT
//   state_dbg        current FSM state encoding
// -----------------------------------------------------------------------------
module spi_latency_reader #(
   parameter int CLK_DIV   = 16,
   parameter int ACK_DELAY = 100,
   parameter int GAP       = 32,
   parameter int TIMEOUT   = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interrupt,
   output logic        interrupt_ack,
   output logic        SCK,
   output logic        SSEL,
   output logic        MOSI,
   input  logic        MISO,
   output logic [31:0] int_ack_latency,
   output logic [31:0] spi_latency,
   output logic        result_valid,
   output logic        timeout_err,
   output logic        busy,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] S_DUMMY    = 3'd0;
   localparam logic [2:0] S_WAIT_INT = 3'd1;
   localparam logic [2:0] S_ACK_DLY  = 3'd2;
   localparam logic [2:0] S_ACK_HOLD = 3'd3;
   localparam logic [2:0] S_GAP_W    = 3'd4;
   localparam logic [2:0] S_XFER     = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam logic [1:0] PH_LEAD  = 2'd0;
   localparam logic [1:0] PH_LOW   = 2'd1;
   localparam logic [1:0] PH_HIGH  = 2'd2;
   localparam logic [1:0] PH_TRAIL = 2'd3;

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [31:0] ACK_LAST = 32'(ACK_DELAY - 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0] GAP_LAST = 32'((GAP > 1) ? GAP - 1 : 1);

   logic [2:0]  state;
   logic [31:0] cnt;
   logic [1:0]  hold_cnt;
   logic        int_m, int_s;
   logic        miso_m, miso_s;

   logic        frame_active;
   logic [1:0]  phase;
   logic [7:0]  div_cnt;
   logic [6:0]  bit_cnt;
   logic [6:0]  bit_last;
   logic [63:0] shift_reg;
   logic        frame_start;
   logic        frame_done;

   assign MOSI      = 1'b0;
   assign busy      = (state != S_WAIT_INT);
   assign state_dbg = state;

   // Two-flop synchronizers for the asynchronous inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_m  <= 1'b0;
         int_s  <= 1'b0;
         miso_m <= 1'b0;
         miso_s <= 1'b0;
      end else begin
         int_m  <= interrupt;
         int_s  <= int_m;
         miso_m <= MISO;
         miso_s <= miso_m;
      end
   end

   // The GAP_W exit and the frame start happen on the same edge, so SSEL
   // falls exactly GAP cycles after the synchronized interrupt falls
   // (ACK_HOLD already accounts for one of those cycles by preloading cnt).
   assign frame_start = ((state == S_DUMMY) && !frame_active) ||
                        ((state == S_GAP_W) && (cnt >= GAP_LAST));
   assign frame_done  = frame_active && (phase == PH_TRAIL) && (div_cnt == DIV_LAST);
   assign bit_last    = (state == S_XFER) ? 7'd63 : 7'd7;

   // SPI frame engine: lead-in (SCK high), N x (low half, high half), trail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_active <= 1'b0;
         phase        <= PH_LEAD;
         div_cnt      <= 8'd0;
         bit_cnt      <= 7'd0;
         SCK          <= 1'b1;
         SSEL         <= 1'b1;
         shift_reg    <= 64'd0;
      end else if (frame_start) begin
         frame_active <= 1'b1;
         phase        <= PH_LEAD;
         div_cnt      <= 8'd0;
         bit_cnt      <= 7'd0;
         SCK          <= 1'b1;
         SSEL         <= 1'b0;
      end else if (frame_active) begin
         if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
         end else begin
            div_cnt <= 8'd0;
            case (phase)
               PH_LEAD: begin
                  phase <= PH_LOW;
                  SCK   <= 1'b0;
               end
               PH_LOW: begin
                  phase <= PH_HIGH;
                  SCK   <= 1'b1;
               end
               PH_HIGH: begin
                  // Last clk of the high half: capture the bit.
                  shift_reg <= {shift_reg[62:0], miso_s};
                  if (bit_cnt == bit_last) begin
                     phase <= PH_TRAIL;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                     phase   <= PH_LOW;
                     SCK     <= 1'b0;
                  end
               end
               default: begin
                  frame_active <= 1'b0;
                  phase        <= PH_LEAD;
                  SSEL         <= 1'b1;
               end
            endcase
         end
      end
   end

   // Control FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_DUMMY;
         cnt             <= 32'd0;
         hold_cnt        <= 2'd0;
         interrupt_ack   <= 1'b0;
         int_ack_latency <= 32'd0;
         spi_latency     <= 32'd0;
         result_valid    <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_DUMMY: begin
               if (frame_done) state <= S_WAIT_INT;
            end
            S_WAIT_INT: begin
               if (hold_cnt != 2'd0) begin
                  hold_cnt <= hold_cnt - 2'd1;
               end else if (int_s) begin
                  cnt   <= 32'd0;
                  state <= S_ACK_DLY;
               end
            end
            S_ACK_DLY: begin
               if (cnt == ACK_LAST) begin
                  interrupt_ack <= 1'b1;
                  cnt           <= 32'd0;
                  state         <= S_ACK_HOLD;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_ACK_HOLD: begin
               if (!int_s) begin
                  cnt   <= 32'd1;
                  state <= S_GAP_W;
               end else if (cnt == TO_LAST) begin
                  timeout_err   <= 1'b1;
                  interrupt_ack <= 1'b0;
                  hold_cnt      <= 2'd2;
                  state         <= S_WAIT_INT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_GAP_W: begin
               if (cnt >= GAP_LAST) state <= S_XFER;
               else                 cnt   <= cnt + 32'd1;
            end
            S_XFER: begin
               if (frame_done) state <= S_DONE;
            end
            S_DONE: begin
               // Byte k of the frame sits at shift_reg[63-8k -: 8].
               int_ack_latency <= {shift_reg[39:32], shift_reg[47:40],
                                   shift_reg[55:48], shift_reg[63:56]};
               spi_latency     <= {shift_reg[7:0],   shift_reg[15:8],
                                   shift_reg[23:16], shift_reg[31:24]};
               result_valid    <= 1'b1;
               interrupt_ack   <= 1'b0;
               hold_cnt        <= 2'd2;
               state           <= S_WAIT_INT;
            end
            default: state <= S_DUMMY;
         endcase
      end
   end

endmodule

// File: doc/spi_latency_reader.md
SPI_LATENCY_READER -- requirements
Module: spi_latency_reader

Interface
REQ-001 Parameter CLK_DIV, default 16, SCK half-period in clk cycles; legal range 12..255.
REQ-002 Parameter ACK_DELAY, default 100, clk cycles from interrupt rise to interrupt_ack rise; legal range 1..2^16-1.
REQ-003 Parameter GAP, default 32, clk cycles from interrupt fall to SSEL assertion.
REQ-004 Parameter TIMEOUT, default 1000000, maximum clk cycles for interrupt to fall after interrupt_ack rises.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 interrupt  in  1  request from the latency target; synchronized through 2 flops internally.
REQ-008 interrupt_ack  out  1  acknowledge to the target; idle low.
REQ-009 SCK  out  1  SPI clock, SPI mode 3 (idle high).
REQ-010 SSEL  out  1  SPI slave select, active low.
REQ-011 MOSI  out  1  SPI data out; constant 0.
REQ-012 MISO  in  1  SPI data in; synchronized through 2 flops internally.
REQ-013 int_ack_latency  out  32  last received interrupt-to-ack count.
REQ-014 spi_latency  out  32  last received ack-to-SPI count.
REQ-015 result_valid  out  1  one-cycle pulse when both results update.
REQ-016 timeout_err  out  1  sticky; set on ack timeout.
REQ-017 busy  out  1  high in every state except WAIT_INT.

Function
REQ-018 State machine: DUMMY, WAIT_INT, ACK_DLY, ACK_HOLD, GAP_W, XFER, DONE.
REQ-019 DUMMY: first state after reset; perform one 1-byte SPI transfer and discard the received byte; then go to WAIT_INT.
REQ-020 WAIT_INT: on synchronized interrupt = 1, clear the delay counter and go to ACK_DLY.
REQ-021 ACK_DLY: count ACK_DELAY cycles, then drive interrupt_ack = 1 and go to ACK_HOLD.
REQ-022 ACK_HOLD: wait for synchronized interrupt = 0, then go to GAP_W.
REQ-023 ACK_HOLD timeout: if TIMEOUT cycles elapse first, set timeout_err, drive interrupt_ack = 0, and go to WAIT_INT.
REQ-024 GAP_W: wait GAP cycles, keeping interrupt_ack = 1, then go to XFER.
REQ-025 XFER: one SSEL-low frame of exactly 8 bytes.
REQ-026 Frame timing:
  - SSEL falls; SCK stays high for CLK_DIV cycles.
  - Each bit is one SCK low half then one SCK high half, each CLK_DIV cycles.
  - MISO is sampled at the last clk of each high half.
  - After the 64th bit, SCK stays high and SSEL rises CLK_DIV cycles later.
REQ-027 Bit order within each byte is MSB first; bytes are little-endian.
REQ-028 Byte mapping: bytes 0-3 are int_ack_latency[7:0]..[31:24]; bytes 4-7 are spi_latency[7:0]..[31:24].
REQ-029 DONE, single cycle:
  - load int_ack_latency and spi_latency from the shift register;
  - pulse result_valid;
  - drive interrupt_ack = 0;
  - go to WAIT_INT.
REQ-030 Outputs hold their values between results; partial frames never update the outputs.
REQ-031 WAIT_INT does not accept a new interrupt until at least 2 cycles after interrupt_ack falls.
REQ-032 A high synchronized interrupt in DUMMY is ignored and is accepted in WAIT_INT after the dummy transfer completes.
REQ-033 timeout_err clears only on rst.

Reset
REQ-034 While rst = 1, outputs are: interrupt_ack = 0, SCK = 1, SSEL = 1, MOSI = 0, int_ack_latency = 0, spi_latency = 0, result_valid = 0, timeout_err = 0, busy = 1; state is DUMMY.
REQ-035 rst asserted mid-frame forces SSEL = 1 and SCK = 1 immediately (asynchronously); the dummy transfer restarts after release.

Verification
REQ-036 Release rst with MISO = 1 -> one 8-bit frame (8 SCK falling edges) then SSEL = 1; result_valid stays 0; busy falls.
REQ-037 Slave model returns bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 after interrupt -> int_ack_latency = 0x44332211, spi_latency = 0x88776655, one result_valid pulse, interrupt_ack = 0 afterwards.
REQ-038 interrupt rises at cycle T -> interrupt_ack rises at T + ACK_DELAY + 2 (±1); SSEL falls GAP cycles after the synchronized interrupt falls.
REQ-039 interrupt held high for TIMEOUT + 10 cycles after ack -> timeout_err = 1, interrupt_ack = 0, no SSEL activity, results unchanged.
REQ-040 rst pulsed during byte 3 of XFER -> SSEL = 1 at once, outputs = 0, next activity is the dummy frame.
REQ-041 Two back-to-back interrupt cycles with different data -> both results reported in order; interrupt_ack low for at least 2 cycles between them.
